// File: rtl/mult35_issue_collect_pkg.sv
// Shared constants, result record and helpers for the multiplier issue/collect wrapper.
package mult35_issue_collect_pkg;

  localparam int unsigned W_DEF       = 35;
  localparam int unsigned MUL_LAT_DEF = 17;
  localparam int unsigned TAG_W_DEF   = 4;

  typedef struct packed {
    logic [2*W_DEF-1:0] prod;
    logic [TAG_W_DEF-1:0] tag;
  } result_t;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    longint unsigned v;
    res = 0;
    v   = 1;
    while (v < longint'(value)) begin
      v   = v << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_ff.sv
// Flop-based synchronous FIFO with level output; push into a full FIFO succeeds only with a pop.
module sync_fifo_ff
  import mult35_issue_collect_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [Width-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [Width-1:0]            rdata_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [clog2(Depth+1)-1:0]   level_o
);

  localparam int unsigned LvlW = clog2(Depth + 1);
  localparam int unsigned PtrW = (clog2(Depth) > 0) ? clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LvlW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = ptr_inc(wptr_q);
    if (do_pop)  rptr_d = ptr_inc(rptr_q);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mult35_issue_collect.sv
// Flow-control wrapper around a fixed-latency 35x35 multiplier: credit-based issue, tagged
// delay line tracking each operation, and a result FIFO that absorbs consumer back-pressure.
module mult35_issue_collect
  import mult35_issue_collect_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TAG_W   = TAG_W_DEF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [W-1:0]                IN_A,
  input  logic [W-1:0]                IN_B,
  input  logic [TAG_W-1:0]            IN_TAG,
  output logic [W-1:0]                MUL_A,
  output logic [W-1:0]                MUL_B,
  input  logic [2*W-1:0]              MUL_P,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [2*W-1:0]              OUT_PROD,
  output logic [TAG_W-1:0]            OUT_TAG,
  output logic [clog2(DEPTH+1)-1:0]   LEVEL,
  output logic                        OVF_ERR
);

  localparam int unsigned LvlW = clog2(DEPTH + 1);
  localparam int unsigned InfW = clog2(MUL_LAT + 2);
  localparam int unsigned SumW = ((LvlW > InfW) ? LvlW : InfW) + 1;

  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic [MUL_LAT:0] vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [MUL_LAT+1];
  logic [TAG_W-1:0] tag_d [MUL_LAT+1];
  logic [InfW-1:0]  inflight_q, inflight_d;
  logic             ovf_q, ovf_d;
  logic             accept, capture, pop;
  logic             fifo_empty, fifo_full;
  logic [SumW-1:0]  credit_used;
  result_t          wr_rec, rd_rec;

  // Credits count both in-flight ops and stored results, from registers only, so a capture
  // always finds room regardless of what the consumer does.
  assign credit_used = SumW'(inflight_q) + SumW'(LEVEL);
  assign IN_READY    = ~RST & (credit_used < SumW'(DEPTH));
  assign accept      = IN_VALID & IN_READY;
  assign capture     = vld_q[MUL_LAT];
  assign OUT_VALID   = ~fifo_empty;
  assign pop         = OUT_VALID & OUT_READY;

  always_comb begin
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    inflight_d = inflight_q;
    ovf_d      = ovf_q | (capture & fifo_full & ~pop);
    if (accept) begin
      mul_a_d = IN_A;
      mul_b_d = IN_B;
    end
    vld_d    = {vld_q[MUL_LAT-1:0], accept};
    tag_d[0] = IN_TAG;
    for (int unsigned i = 1; i <= MUL_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    unique case ({accept, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      vld_q      <= '0;
      inflight_q <= '0;
      ovf_q      <= 1'b0;
      for (int unsigned i = 0; i <= MUL_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
      for (int unsigned i = 0; i <= MUL_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign wr_rec = '{prod: MUL_P, tag: tag_q[MUL_LAT]};

  sync_fifo_ff #(
    .Width ($bits(result_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (capture),
    .wdata_i (wr_rec),
    .pop_i   (pop),
    .rdata_o (rd_rec),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (LEVEL)
  );

  assign MUL_A    = mul_a_q;
  assign MUL_B    = mul_b_q;
  assign OUT_PROD = rd_rec.prod;
  assign OUT_TAG  = rd_rec.tag;
  assign OVF_ERR  = ovf_q;

endmodule

// File: tb/tb_mult35_issue_collect.sv
// Randomised bench for mult35_issue_collect: queue-based reference model checked every cycle,
// a pipelined multiplier stand-in, and directed literal checks of latency and products.
module tb_mult35_issue_collect;

  localparam int unsigned W       = 35;
  localparam int unsigned MUL_LAT = 17;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned TAG_W   = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             IN_VALID;
  logic             IN_READY;
  logic [W-1:0]     IN_A, IN_B;
  logic [TAG_W-1:0] IN_TAG;
  logic [W-1:0]     MUL_A, MUL_B;
  logic [2*W-1:0]   MUL_P;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [2*W-1:0]   OUT_PROD;
  logic [TAG_W-1:0] OUT_TAG;
  logic [5:0]       LEVEL;
  logic             OVF_ERR;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  mult35_issue_collect #(
    .W       (W),
    .MUL_LAT (MUL_LAT),
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
    .IN_TAG    (IN_TAG),
    .MUL_A     (MUL_A),
    .MUL_B     (MUL_B),
    .MUL_P     (MUL_P),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_PROD  (OUT_PROD),
    .OUT_TAG   (OUT_TAG),
    .LEVEL     (LEVEL),
    .OVF_ERR   (OVF_ERR)
  );

  always #5 CLK = ~CLK;

  // Multiplier stand-in: product of sampled operands appears MUL_LAT cycles later, no reset.
  logic [2*W-1:0] mpipe [MUL_LAT];
  always @(posedge CLK) begin
    mpipe[0] <= {{W{1'b0}}, MUL_A} * {{W{1'b0}}, MUL_B};
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign MUL_P = mpipe[MUL_LAT-1];

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ops in flight with the cycle they land in the FIFO, plus the FIFO itself.
  typedef struct {
    int             due;
    logic [2*W-1:0] prod;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t infl_q[$];
  op_t fifo_q[$];
  op_t op;
  int  mcyc = 0;
  bit  m_ovf = 1'b0;
  bit  m_acc, m_pop, m_cap;
  logic [2*W-1:0] a70, b70;

  always @(posedge CLK) begin
    if (RST) begin
      infl_q.delete();
      fifo_q.delete();
      m_ovf = 1'b0;
    end else begin
      m_acc = IN_VALID && ((infl_q.size() + fifo_q.size()) < DEPTH);
      m_pop = (fifo_q.size() > 0) && OUT_READY;
      m_cap = (infl_q.size() > 0) && (infl_q[0].due == mcyc);
      if (m_pop) void'(fifo_q.pop_front());
      if (m_cap) begin
        op = infl_q.pop_front();
        if (fifo_q.size() < DEPTH) fifo_q.push_back(op);
        else m_ovf = 1'b1;
      end
      if (m_acc) begin
        a70     = {{W{1'b0}}, IN_A};
        b70     = {{W{1'b0}}, IN_B};
        op.due  = mcyc + MUL_LAT + 1;
        op.prod = a70 * b70;
        op.tag  = IN_TAG;
        infl_q.push_back(op);
      end
    end
    mcyc++;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("in_ready", IN_READY,
          (!RST && ((infl_q.size() + fifo_q.size()) < DEPTH)) ? 1 : 0);
      chk("out_valid", OUT_VALID, (fifo_q.size() > 0) ? 1 : 0);
      chk("level", LEVEL, fifo_q.size());
      chk("ovf_err", OVF_ERR, m_ovf);
      if (fifo_q.size() > 0) begin
        chk("out_prod", OUT_PROD, fifo_q[0].prod);
        chk("out_tag", OUT_TAG, fifo_q[0].tag);
      end
    end
  end

  logic [TAG_W-1:0] tag_ctr = '0;

  task automatic set_rand;
    logic [63:0] r;
    r    = {$urandom(), $urandom()};
    IN_A = ($urandom_range(0, 7) == 0) ? '1 : r[W-1:0];
    r    = {$urandom(), $urandom()};
    IN_B = ($urandom_range(0, 7) == 0) ? '1 : r[W-1:0];
    IN_TAG  = tag_ctr;
    tag_ctr = tag_ctr + 1'b1;
  endtask

  // Offer n ops back to back; called and returns #1 after a rising edge.
  task automatic stream(input int n, input bit rnd_ready, output int stalls);
    int  sent, guard;
    bit  took;
    sent   = 0;
    guard  = 0;
    stalls = 0;
    IN_VALID = 1'b1;
    set_rand();
    while (sent < n && guard < 4000) begin
      if (rnd_ready) OUT_READY = $urandom_range(0, 1);
      @(negedge CLK);
      took = IN_READY;
      @(posedge CLK);
      #1;
      guard++;
      if (took) begin
        sent++;
        if (sent < n) set_rand();
      end else begin
        stalls++;
      end
    end
    IN_VALID = 1'b0;
    chk("stream_done", sent, n);
  endtask

  // One op on an idle block; checks latency, product and tag against literals.
  task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TAG_W-1:0] t, input logic [2*W-1:0] exp,
                           input string name);
    int k;
    OUT_READY = 1'b1;
    IN_A = a;
    IN_B = b;
    IN_TAG = t;
    IN_VALID = 1'b1;
    k = 0;
    @(negedge CLK);
    while (!IN_READY && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk({name, "_issue"}, IN_READY, 1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!OUT_VALID && k < 40);
    chk({name, "_latency"}, k, MUL_LAT + 2);
    chk({name, "_prod"}, OUT_PROD, exp);
    chk({name, "_tag"}, OUT_TAG, t);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk({name, "_level_after"}, LEVEL, 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int stalls, seen;
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN_A = '0;
    IN_B = '0;
    IN_TAG = '0;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_mul_a", MUL_A, 0);
    chk("rst_ovf", OVF_ERR, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_in_ready", IN_READY, 1);
    @(posedge CLK);
    #1;

    single_op(35'd3, 35'd5, 4'd1, 70'd15, "single");
    single_op('1, '1, 4'd2, 70'h3F_FFFF_FFF0_0000_0001, "max_sq");
    single_op('1, '0, 4'd3, 70'd0, "max_zero");

    OUT_READY = 1'b1;
    stream(100, 1'b0, stalls);
    chk("stream_no_stall", stalls, 0);
    repeat (30) @(posedge CLK);
    #1;

    // Back-pressure: credits run out at exactly DEPTH outstanding ops.
    OUT_READY = 1'b0;
    stream(DEPTH, 1'b0, stalls);
    IN_VALID = 1'b1;
    set_rand();
    @(negedge CLK);
    chk("bp_in_ready_drop", IN_READY, 0);
    repeat (25) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("bp_level_full", LEVEL, DEPTH);
    chk("bp_in_ready_low", IN_READY, 0);
    chk("bp_ovf", OVF_ERR, 0);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge CLK);
      if (OUT_VALID && OUT_READY) seen++;
    end
    chk("drain_count", seen, DEPTH);
    chk("drain_level", LEVEL, 0);
    @(posedge CLK);
    #1;

    // Near-full churn with a randomly stalling consumer.
    OUT_READY = 1'b0;
    stream(DEPTH - 2, 1'b0, stalls);
    stream(80, 1'b1, stalls);
    OUT_READY = 1'b1;
    repeat (60) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("churn_level", LEVEL, 0);
    chk("churn_ovf", OVF_ERR, 0);
    @(posedge CLK);
    #1;

    // Reset mid-flight: nothing from the discarded ops may surface.
    stream(5, 1'b0, stalls);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (OUT_VALID) seen++;
    end
    chk("midrst_no_out", seen, 0);
    @(posedge CLK);
    #1;
    single_op(35'd7, 35'd9, 4'd9, 70'd63, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
